// File: rtl/fm_sb_capture.sv
// Spy-buffer write front end: circular capture into SB_MEM with trigger/post-count/freeze, plus sequential playback.
// Optional trigger timestamp counter enabled by defining FM_SB_CAPTURE_TS_EN.
module fm_sb_capture #(
  parameter int DW     = 256,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     fm_data_i,
  input  logic              fm_vld_i,
  input  logic [1:0]        pb_mode_i,
  input  logic              freeze_req_i,
  input  logic              trig_i,
  input  logic              rearm_i,
  input  logic [ADDR_W-1:0] post_trig_len_i,
  input  logic [ADDR_W-1:0] pb_len_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic [DW-1:0]     pb_data_o,
  output logic              pb_vld_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic              wrapped_o,
  output logic              trig_seen_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic              frozen_o,
  output logic [31:0]       trig_ts_o
);

  typedef enum logic [2:0] {IDLE, RUN, POST, FROZEN, PLAY} state_t;

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wrapped;
  logic              trig_seen;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] post_cnt;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_waddr_r;
  logic [DW-1:0]     mem_wdata_r;
  logic              mem_re_r;
  logic [ADDR_W-1:0] mem_raddr_r;
  logic [ADDR_W-1:0] rd_cnt;
  logic              re_d1;
  logic [DW-1:0]     pb_data_r;
  logic              pb_vld_r;
  logic              wr_fire;
  logic [ADDR_W-1:0] pb_last;

  // pb_len_i = 0 underflows to all-ones, which gives the full-depth loop for free.
  assign pb_last = pb_len_i - ONE;

  // Trigger beats a RUN-exit request, so the trigger word is still written.
  assign wr_fire = !rearm_i && !freeze_req_i && fm_vld_i &&
                   (((state == RUN) && (trig_i || (pb_mode_i == 2'b00))) ||
                    ((state == POST) && (post_cnt != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      wrapped     <= 1'b0;
      trig_seen   <= 1'b0;
      trig_addr   <= '0;
      post_cnt    <= '0;
      mem_we_r    <= 1'b0;
      mem_waddr_r <= '0;
      mem_wdata_r <= '0;
      mem_re_r    <= 1'b0;
      mem_raddr_r <= '0;
      rd_cnt      <= '0;
      re_d1       <= 1'b0;
      pb_data_r   <= '0;
      pb_vld_r    <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      if (rearm_i) begin
        state     <= IDLE;
        wr_ptr    <= '0;
        wrapped   <= 1'b0;
        trig_seen <= 1'b0;
        trig_addr <= '0;
        post_cnt  <= '0;
        mem_re_r  <= 1'b0;
        re_d1     <= 1'b0;
        pb_vld_r  <= 1'b0;
      end else begin
        re_d1    <= mem_re_r;
        pb_vld_r <= re_d1;
        if (re_d1) pb_data_r <= mem_rdata_i;
        mem_re_r <= 1'b0;

        if (wr_fire) begin
          mem_we_r    <= 1'b1;
          mem_waddr_r <= wr_ptr;
          mem_wdata_r <= fm_data_i;
          wr_ptr      <= wr_ptr + ONE;
          if (&wr_ptr) wrapped <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (pb_mode_i == 2'b01) begin
              state  <= PLAY;
              rd_cnt <= '0;
            end else if (pb_mode_i == 2'b00 && !freeze_req_i) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (freeze_req_i) begin
              state <= FROZEN;
            end else if (trig_i) begin
              state     <= POST;
              trig_seen <= 1'b1;
              trig_addr <= wr_ptr;
              post_cnt  <= post_trig_len_i;
            end else if (pb_mode_i != 2'b00) begin
              state <= IDLE;
            end
          end
          POST: begin
            if (freeze_req_i || post_cnt == '0) begin
              state <= FROZEN;
            end else if (fm_vld_i) begin
              post_cnt <= post_cnt - ONE;
              if (post_cnt == ONE) state <= FROZEN;
            end
          end
          FROZEN: begin
            if (pb_mode_i == 2'b01) begin
              state  <= PLAY;
              rd_cnt <= '0;
            end
          end
          PLAY: begin
            if (pb_mode_i == 2'b01) begin
              mem_re_r    <= 1'b1;
              mem_raddr_r <= rd_cnt;
              rd_cnt      <= (rd_cnt == pb_last) ? '0 : rd_cnt + ONE;
            end else if (!mem_re_r && !re_d1) begin
              state <= trig_seen ? FROZEN : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FM_SB_CAPTURE_TS_EN
  logic [31:0] ts_cnt;
  logic [31:0] trig_ts_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt    <= '0;
      trig_ts_r <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (rearm_i)
        trig_ts_r <= '0;
      else if (state == RUN && !freeze_req_i && trig_i)
        trig_ts_r <= ts_cnt;
    end
  end

  assign trig_ts_o = trig_ts_r;
`else
  assign trig_ts_o = '0;
`endif

  assign mem_we_o    = mem_we_r;
  assign mem_waddr_o = mem_waddr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_re_o    = mem_re_r;
  assign mem_raddr_o = mem_raddr_r;
  assign pb_data_o   = pb_data_r;
  assign pb_vld_o    = pb_vld_r;
  assign wr_ptr_o    = wr_ptr;
  assign wrapped_o   = wrapped;
  assign trig_seen_o = trig_seen;
  assign trig_addr_o = trig_addr;
  assign frozen_o    = (state == FROZEN);

endmodule

// File: doc/fm_sb_capture.md
Name: fm_sb_capture

Overview:
- Write-side front end of one fast-monitoring spy buffer.
- Takes one monitored stream (fm_data/fm_vld, up to 256 bits) and drives the write port of the SB_MEM dual-port RAM as a circular buffer.
- Handles trigger with post-trigger count, freeze and re-arm, and exposes pointer/trigger metadata for the SB_META register block.
- In playback mode it reads the same RAM back sequentially onto a replay stream.

Parameters:
- DW, 256, data width of the monitored word (≤ 256, matches mon_dw_max).
- ADDR_W, 10, SB_MEM address width; depth = 2**ADDR_W.

Ports:
- clk  in  1  fabric clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fm_data_i  in  DW  monitored data word.
- fm_vld_i  in  1  monitored word valid.
- pb_mode_i  in  2  00 capture, 01 playback, 10/11 hold.
- freeze_req_i  in  1  level; stop writing immediately.
- trig_i  in  1  single-cycle trigger pulse.
- rearm_i  in  1  single-cycle pulse; clear pointers, return to IDLE.
- post_trig_len_i  in  ADDR_W  valid words written after the trigger word.
- pb_len_i  in  ADDR_W  playback length; 0 = full depth.
- mem_we_o  out  1  RAM write enable.
- mem_waddr_o  out  ADDR_W  RAM write address.
- mem_wdata_o  out  DW  RAM write data.
- mem_re_o  out  1  RAM read enable.
- mem_raddr_o  out  ADDR_W  RAM read address.
- mem_rdata_i  in  DW  RAM read data, valid 1 cycle after mem_re_o.
- pb_data_o  out  DW  playback data.
- pb_vld_o  out  1  playback valid.
- wr_ptr_o  out  ADDR_W  next write address.
- wrapped_o  out  1  sticky; buffer has wrapped at least once.
- trig_seen_o  out  1  sticky; trigger accepted.
- trig_addr_o  out  ADDR_W  address of the trigger word.
- frozen_o  out  1  state is FROZEN.
- trig_ts_o  out  32  trigger timestamp (see Optional Feature).

Behaviour:
- Reset: every output 0, state IDLE, all counters 0.
- States: IDLE, RUN, POST, FROZEN, PLAY.
- Priority each cycle: rearm_i > freeze_req_i > trig_i > write.
- rearm_i in any state → IDLE next cycle; clears wr_ptr, wrapped, trig_seen, trig_addr, trig_ts; aborts playback (pb_vld_o 0 next cycle).
- IDLE:
  - pb_mode 00 and freeze_req 0 → RUN.
  - pb_mode 01 → PLAY.
  - Otherwise stay in IDLE.
- RUN:
  - Each fm_vld_i=1 cycle registers a write: mem_we_o/mem_waddr_o=wr_ptr/mem_wdata_o appear 1 cycle later.
  - wr_ptr increments modulo 2**ADDR_W. The increment from 2**ADDR_W-1 to 0 sets wrapped_o.
  - trig_i → POST; trig_seen_o=1; trig_addr_o = wr_ptr of the trigger cycle, whether or not a word is written that cycle; post counter loads post_trig_len_i.
  - freeze_req_i → FROZEN; no write that cycle.
  - pb_mode ≠ 00 → IDLE.
- POST:
  - Writes continue as in RUN. Each valid write after the trigger cycle decrements the counter.
  - Counter 0 with no pending write → FROZEN. With post_trig_len_i=0, freeze occurs the cycle after the trigger.
  - Further trig_i ignored (no retrigger).
  - freeze_req_i → FROZEN immediately.
- FROZEN:
  - No writes; frozen_o=1; metadata held.
  - Exit only via rearm_i, or via pb_mode 01 → PLAY (metadata preserved).
- PLAY:
  - mem_re_o=1 each cycle; mem_raddr_o counts 0..L-1 then wraps to 0 and loops, where L = pb_len_i or 2**ADDR_W when pb_len_i=0.
  - pb_data_o = mem_rdata_i and pb_vld_o = 1, registered, 2 cycles after the matching mem_re_o (RAM latency + output register).
  - pb_mode ≠ 01 → stop issuing reads; drain in-flight reads (pb_vld_o may stay 1 for ≤ 2 cycles); then → FROZEN if trig_seen else IDLE.
- Simultaneous events:
  - freeze_req_i and trig_i in RUN: freeze wins, trig_seen stays 0.
  - fm_vld_i in the freeze cycle: word dropped.
- wr_ptr_o, wrapped_o and trig_addr_o are registered; they update the cycle after the causing event.

Optional Feature:
- Macro FM_SB_CAPTURE_TS_EN.
- Defined: free-running 32-bit cycle counter, reset to 0, wraps at 2**32. Latched into trig_ts_o on trigger acceptance.
- Not defined: no counter; trig_ts_o tied to 0.

Test Plan:
- ADDR_W=4, RUN, 20 consecutive valid words D0..D19 → writes to addr 0..15 then 0..3; wrapped_o=1 after the 16th write; wr_ptr_o=4.
- Trigger on 5th valid word, post_trig_len_i=3 → trig_addr_o=4; exactly 4 more writes (addr 4..7); frozen_o=1; wr_ptr_o=8; further vld produces no mem_we_o.
- freeze_req_i and trig_i same cycle in RUN → FROZEN; trig_seen_o=0; no write that cycle.
- After capture, pb_mode 01, pb_len_i=5 → mem_raddr_o 0,1,2,3,4,0,…; pb_data_o matches stored words 2 cycles after each read; pb_mode 00 → pb_vld_o low within 2 cycles; FROZEN.
- Assert rst_n low mid-POST → all outputs 0 asynchronously; rearm_i in FROZEN → IDLE; wr_ptr_o=0; wrapped_o=0.
- With FM_SB_CAPTURE_TS_EN, trigger 100 cycles after reset release → trig_ts_o=100 (±0); without the macro → trig_ts_o=0.
